wb_unit: RTL and testbench

- Write-back stage; the writer side of the register-file interface whose read side (Rdata1/Rdata2) is consumed by ID.
- Accepts retiring instructions from EX/MEM, decodes the destination register and selects the write data (ALU Result, memory data, or link address).
- Drives the register-file write port (Wen/Wreg/Wdata) one cycle after acceptance.
- Handles load-data latency with a small FSM, and exposes a pending-destination hint so ID can stall on load-use hazards.

---
 rtl/wb_unit.sv | 79 +++++++
 tb/tb_wb_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// wb_unit: write-back stage (in: clk rst in_valid ins result nextpc mem_valid mem_rdata; out: in_ready wen wreg wdata pend_valid pend_reg err retired)
module wb_unit #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ins,
  input  logic [31:0]      result,
  input  logic [31:0]      nextpc,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rdata,
  output logic             wen,
  output logic [4:0]       wreg,
  output logic [31:0]      wdata,
  output logic             pend_valid,
  output logic [4:0]       pend_reg,
  output logic             err,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt;
  logic [5:0] op, fn;
  logic [4:0] dest, wreg_n;
  logic [31:0] wdata_n;
  logic is_r, is_lw, link, writes, acc, done, tmo, wen_n;
  logic unused_ins;
  assign unused_ins = ^{ins[25:21], ins[10:6]};
  assign in_ready = state == IDLE;
  always_comb begin
    op = ins[31:26];
    fn = ins[5:0];
    is_r = op == 6'h00;
    is_lw = op == 6'h23;
    link = op == 6'h03 || (is_r && fn == 6'h09);
    writes = (is_r && fn != 6'h08) || op[5:3] == 3'b001 || op == 6'h03;
    dest = is_r ? ins[15:11] : op == 6'h03 ? 5'd31 : ins[20:16];
    acc = in_valid && state == IDLE;
    done = state == LOAD_WAIT && mem_valid;
    tmo = state == LOAD_WAIT && !mem_valid && cnt == TW'(LOAD_TIMEOUT - 1);
    state_n = acc && is_lw ? LOAD_WAIT : (done || tmo) ? IDLE : state;
    wen_n = done ? pend_reg != 5'd0 : acc && writes && dest != 5'd0;
    wreg_n = done ? pend_reg : dest;
    wdata_n = done ? mem_rdata : link ? nextpc : result;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen <= 1'b0;
      wreg <= '0;
      wdata <= '0;
      pend_valid <= 1'b0;
      pend_reg <= '0;
      err <= 1'b0;
      retired <= '0;
      cnt <= '0;
    end else begin
      wen <= wen_n;
      if (wen_n) begin
        wreg <= wreg_n;
        wdata <= wdata_n;
        retired <= retired + CNT_W'(1);
      end
      if (acc && is_lw) begin
        pend_valid <= 1'b1;
        pend_reg <= dest;
        cnt <= '0;
      end else if (done || tmo) pend_valid <= 1'b0;
      else if (state == LOAD_WAIT) cnt <= cnt + TW'(1);
      if (tmo) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed stimulus against a cycle-level behavioural model of wb_unit plus literal checks
module tb_wb_unit;
  localparam int TO = 16;
  logic clk = 0, rst = 1, in_valid = 0, mem_valid = 0;
  logic [31:0] ins = 0, result = 0, nextpc = 0, mem_rdata = 0;
  logic in_ready, wen, pend_valid, err;
  logic [4:0] wreg, pend_reg;
  logic [31:0] wdata, retired;
  int n_chk = 0, n_pass = 0;
  bit m_busy = 0, m_pend = 0, m_err = 0, m_wen = 0;
  int m_age = 0;
  logic [4:0] m_wreg = 0, m_preg = 0;
  logic [31:0] m_wdata = 0, m_ret = 0;

  wb_unit dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .result(result), .nextpc(nextpc), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .wen(wen), .wreg(wreg), .wdata(wdata), .pend_valid(pend_valid), .pend_reg(pend_reg),
    .err(err), .retired(retired));

  always #5 clk = ~clk;

  function automatic int dest_of(logic [31:0] i);
    if (i[31:26] == 6'h00) return i[5:0] == 6'h08 ? -1 : int'(i[15:11]);
    if (i[31:26] == 6'h03) return 31;
    if (i[31:26] inside {[6'h08:6'h0f]}) return int'(i[20:16]);
    return -1;
  endfunction

  function automatic logic [31:0] data_of(logic [31:0] i, logic [31:0] r, logic [31:0] n);
    return (i[31:26] == 6'h03 || (i[31:26] == 6'h00 && i[5:0] == 6'h09)) ? n : r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_pend <= 0; m_err <= 0; m_wen <= 0; m_age <= 0;
      m_wreg <= 0; m_preg <= 0; m_wdata <= 0; m_ret <= 0;
    end else begin
      m_wen <= 0;
      if (!m_busy) begin
        if (in_valid && ins[31:26] == 6'h23) begin
          m_busy <= 1; m_age <= 0; m_pend <= 1; m_preg <= ins[20:16];
        end else if (in_valid && dest_of(ins) > 0) begin
          m_wen <= 1; m_wreg <= 5'(dest_of(ins)); m_wdata <= data_of(ins, result, nextpc);
          m_ret <= m_ret + 1;
        end
      end else if (mem_valid) begin
        m_busy <= 0; m_pend <= 0;
        if (m_preg != 0) begin
          m_wen <= 1; m_wreg <= m_preg; m_wdata <= mem_rdata; m_ret <= m_ret + 1;
        end
      end else if (m_age + 1 == TO) begin
        m_busy <= 0; m_pend <= 0; m_err <= 1;
      end else m_age <= m_age + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_in_ready", 32'(in_ready), 32'(!m_busy));
    chk("m_wen", 32'(wen), 32'(m_wen));
    chk("m_wreg", 32'(wreg), 32'(m_wreg));
    chk("m_wdata", wdata, m_wdata);
    chk("m_pend_valid", 32'(pend_valid), 32'(m_pend));
    chk("m_pend_reg", 32'(pend_reg), 32'(m_preg));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_retired", retired, m_ret);
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r,
                       input logic [31:0] n, input logic mv, input logic [31:0] md);
    in_valid = v; ins = i; result = r; nextpc = n; mem_valid = mv; mem_rdata = md;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_rst();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_retired", retired, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 0;
    drive(1, 32'h02108020, 32, 0, 0, 0);
    chk("add_wen", 32'(wen), 1);
    chk("add_wreg", 32'(wreg), 16);
    chk("add_wdata", wdata, 32);
    chk("add_retired", retired, 1);
    idle(1);
    chk("add_wen_drop", 32'(wen), 0);
    chk("add_wreg_hold", 32'(wreg), 16);
    drive(1, 32'h02100020, 32'h55, 0, 0, 0);
    chk("add_r0_wen", 32'(wen), 0);
    chk("add_r0_retired", retired, 1);
    drive(1, 32'h02000008, 32'h99, 0, 0, 0);
    chk("jr_wen", 32'(wen), 0);
    drive(1, 32'hac040000, 32'h99, 0, 0, 0);
    chk("sw_wen", 32'(wen), 0);
    drive(0, 0, 0, 0, 1, 32'hdead);
    chk("idle_mem_ignored", 32'(wen), 0);
    drive(1, 32'h8c040000, 0, 0, 0, 0);
    chk("lw_ready", 32'(in_ready), 0);
    chk("lw_pend", 32'(pend_valid), 1);
    chk("lw_pend_reg", 32'(pend_reg), 4);
    idle(2);
    chk("lw_still_pend", 32'(pend_valid), 1);
    drive(0, 0, 0, 0, 1, 32'h40);
    chk("lw_wen", 32'(wen), 1);
    chk("lw_wreg", 32'(wreg), 4);
    chk("lw_wdata", wdata, 32'h40);
    chk("lw_pend_clr", 32'(pend_valid), 0);
    chk("lw_ready_back", 32'(in_ready), 1);
    drive(1, 32'h0c000000, 32'h1, 32'h104, 0, 0);
    chk("jal_wreg", 32'(wreg), 31);
    chk("jal_wdata", wdata, 32'h104);
    drive(1, 32'h02002809, 32'h1, 32'h20, 0, 0);
    chk("jalr_wreg", 32'(wreg), 5);
    chk("jalr_wdata", wdata, 32'h20);
    chk("jalr_retired", retired, 4);
    drive(1, 32'h8c070000, 0, 0, 0, 0);
    idle(TO - 1);
    chk("to_not_yet", 32'(err), 0);
    chk("to_pend_hold", 32'(pend_valid), 1);
    idle(1);
    chk("to_err", 32'(err), 1);
    chk("to_pend_clr", 32'(pend_valid), 0);
    chk("to_no_wen", 32'(wen), 0);
    chk("to_ready", 32'(in_ready), 1);
    chk("to_retired", retired, 4);
    pulse_rst();
    chk("err_cleared", 32'(err), 0);
    drive(1, 32'h8c090000, 0, 0, 0, 0);
    idle(TO - 1);
    drive(0, 0, 0, 0, 1, 32'habcd);
    chk("race_wen", 32'(wen), 1);
    chk("race_wreg", 32'(wreg), 9);
    chk("race_wdata", wdata, 32'habcd);
    chk("race_err", 32'(err), 0);
    drive(1, 32'h8c040000, 0, 0, 0, 0);
    idle(1);
    #2 rst = 1;
    #1;
    chk("arst_wen", 32'(wen), 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_pend", 32'(pend_valid), 0);
    chk("arst_pend_reg", 32'(pend_reg), 0);
    chk("arst_retired", retired, 0);
    chk("arst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0, 1, 32'h77);
    chk("arst_late_mem", 32'(wen), 0);
    drive(1, 32'h20010001, 1, 0, 0, 0);
    chk("addi1_wreg", 32'(wreg), 1);
    drive(1, 32'h20020002, 2, 0, 0, 0);
    chk("addi2_wen", 32'(wen), 1);
    chk("addi2_wreg", 32'(wreg), 2);
    drive(1, 32'h20030003, 3, 0, 0, 0);
    chk("addi3_wen", 32'(wen), 1);
    chk("addi3_wdata", wdata, 3);
    chk("addi_retired", retired, 3);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
